// File: rtl/hbm_axi_pkg.sv
// Shared AXI constants, read-master FSM states and an arsize helper for the
// HBM read burst master and its credit counter.
package hbm_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // AXI size encoding: log2 of the bytes carried per beat.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/hbm_rd_burst_master_if.sv
// AXI4 read-address and read-data channel bundle for one HBM pseudo-channel.
// master: the burst master side; slave: the memory/interconnect side.
interface hbm_rd_burst_master_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 33
);

  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/hbm_rd_credit_counter.sv
// Free-space credit counter for the downstream read FIFO. Starts full
// (FIFO_DEPTH), is debited a whole burst when an AR is accepted and gains one
// credit per consumer pop. can_issue looks at the balance after this cycle's
// debit/return so the master can decide next-cycle arvalid from it.
module hbm_rd_credit_counter #(
  parameter int FIFO_DEPTH = 512,
  parameter int BURST_LEN  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic debit,
  input  logic credit_ret,
  output logic can_issue
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW:0] BURST_W = (CW + 1)'(BURST_LEN);

  logic [CW-1:0] credits_q;
  logic [CW-1:0] credits_d;
  logic [CW:0]   sum_s;

  // Next balance: return minus debit, clamped so it never exceeds the FIFO depth.
  always_comb begin
    sum_s = {1'b0, credits_q} + {{CW{1'b0}}, credit_ret}
          - (debit ? BURST_W : {(CW + 1){1'b0}});
    if (sum_s > DEPTH_W) begin
      credits_d = DEPTH_W[CW-1:0];
    end else begin
      credits_d = sum_s[CW-1:0];
    end
    can_issue = ({1'b0, credits_d} >= BURST_W);
  end

  // Credit register, full on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q <= DEPTH_W[CW-1:0];
    end else begin
      credits_q <= credits_d;
    end
  end

endmodule

// File: rtl/hbm_rd_burst_master.sv
// Single-channel AXI4 read master feeding one HBM read FIFO. Issues fixed
// length INCR bursts over a contiguous region, only when the FIFO has room for
// a whole burst, so the R channel is never stalled for lack of space.
// Optional feature macro: HBM_RD_RESP_CHK_EN (sticky rd_err on non-OKAY rresp).
module hbm_rd_burst_master
  import hbm_axi_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int ADDR_WIDTH      = 33,
  parameter int BURST_LEN       = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [15:0]             num_bursts,
  output logic                    busy,
  output logic                    done,
  hbm_rd_burst_master_if.master   m_axi,
  output logic                    fifo_write_enable,
  output logic [DATA_WIDTH-1:0]   fifo_write_data,
  input  logic                    fifo_read_enable,
  output logic                    rd_err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]         MAX_OUT_W = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0]         ONE_OUT   = OW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

  rd_state_e state_q, state_d;
  logic [15:0]           num_bursts_q, num_bursts_d;
  logic [15:0]           issued_q, issued_d;
  logic [OW-1:0]         outstanding_q, outstanding_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_err_q, rd_err_d;

  logic start_acc_s, ar_acc_s, beat_s, last_s, can_issue_s;

  assign start_acc_s = start && (state_q == IDLE);
  assign ar_acc_s    = arvalid_q && m_axi.arready;
  assign beat_s      = m_axi.rvalid && rready_q;
  assign last_s      = beat_s && m_axi.rlast;

  hbm_rd_credit_counter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BURST_LEN  (BURST_LEN)
  ) u_credit (
    .clk        (clk),
    .reset      (reset),
    .debit      (ar_acc_s),
    .credit_ret (fifo_read_enable),
    .can_issue  (can_issue_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave ISSUE on the final AR accept, leave DRAIN once nothing is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_bursts == 16'd0) ? DONE : ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issued_d == num_bursts_q) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (outstanding_q == {OW{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Job bookkeeping: latched length, burst/in-flight counts, next burst address, FIFO push.
  always_comb begin
    num_bursts_d = start_acc_s ? num_bursts : num_bursts_q;
    if (start_acc_s) begin
      issued_d = 16'd0;
      araddr_d = base_addr;
    end else if (ar_acc_s) begin
      issued_d = issued_q + 16'd1;
      araddr_d = araddr_q + ADDR_STEP;
    end else begin
      issued_d = issued_q;
      araddr_d = araddr_q;
    end
    case ({ar_acc_s, last_s})
      2'b10:   outstanding_d = outstanding_q + ONE_OUT;
      2'b01:   outstanding_d = outstanding_q - ONE_OUT;
      default: outstanding_d = outstanding_q;
    endcase
    wr_en_d   = beat_s;
    wr_data_d = beat_s ? m_axi.rdata : wr_data_q;
  end

  // FSM outputs: arvalid holds until accepted, otherwise re-armed only with room and budget.
  always_comb begin
    if (arvalid_q && !m_axi.arready) begin
      arvalid_d = 1'b1;
    end else begin
      arvalid_d = (state_d == ISSUE) && (issued_d < num_bursts_d) &&
                  can_issue_s && (outstanding_d < MAX_OUT_W);
    end
    rready_d = (state_d == ISSUE) || (state_d == DRAIN);
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == DONE);
  end

`ifdef HBM_RD_RESP_CHK_EN
  // Sticky error on any pushed non-OKAY beat; a new job clears it.
  always_comb begin
    if (start_acc_s) begin
      rd_err_d = 1'b0;
    end else if (beat_s && (m_axi.rresp != AXI_RESP_OKAY)) begin
      rd_err_d = 1'b1;
    end else begin
      rd_err_d = rd_err_q;
    end
  end
`else
  logic resp_unused_s;
  assign resp_unused_s = ^m_axi.rresp;
  assign rd_err_d      = 1'b0;
`endif

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_bursts_q  <= 16'd0;
      issued_q      <= 16'd0;
      outstanding_q <= {OW{1'b0}};
      araddr_q      <= {ADDR_WIDTH{1'b0}};
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= {DATA_WIDTH{1'b0}};
      rd_err_q      <= 1'b0;
    end else begin
      num_bursts_q  <= num_bursts_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wr_en_q       <= wr_en_d;
      wr_data_q     <= wr_data_d;
      rd_err_q      <= rd_err_d;
    end
  end

  assign m_axi.araddr      = araddr_q;
  assign m_axi.arlen       = 8'(BURST_LEN - 1);
  assign m_axi.arsize      = axi_size(DATA_WIDTH);
  assign m_axi.arburst     = AXI_BURST_INCR;
  assign m_axi.arvalid     = arvalid_q;
  assign m_axi.rready      = rready_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign fifo_write_enable = wr_en_q;
  assign fifo_write_data   = wr_data_q;
  assign rd_err            = rd_err_q;

endmodule

// File: tb/tb_hbm_rd_burst_master.sv
// Directed bench for hbm_rd_burst_master with an AXI read-slave model.
// Expected AR addresses are queued when a job is started, expected FIFO words
// when the slave hands a beat over; both are popped when the DUT produces them.
module tb_hbm_rd_burst_master;

  localparam int DW = 256;
  localparam int AW = 33;
  localparam int BL = 16;
  localparam logic [AW-1:0] STEP = 33'h200;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   num_bursts;
  logic          busy, done;
  logic          fifo_write_enable;
  logic [DW-1:0] fifo_write_data;
  logic          fifo_read_enable;
  logic          rd_err;

  hbm_rd_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_axi ();

  hbm_rd_burst_master dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .num_bursts        (num_bursts),
    .busy              (busy),
    .done              (done),
    .m_axi             (m_axi),
    .fifo_write_enable (fifo_write_enable),
    .fifo_write_data   (fifo_write_data),
    .fifo_read_enable  (fifo_read_enable),
    .rd_err            (rd_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failures  = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] slv_ar_q[$];

  int beat_idx  = 0;
  int burst_cnt = 0;
  int err_burst = -1;
  int ar_cnt    = 0;
  int push_cnt  = 0;
  int done_cnt  = 0;
  logic rv_en   = 1'b1;

  logic          snap_arvalid = 1'b0;
  logic          snap_rready  = 1'b0;
  logic [AW-1:0] snap_araddr  = '0;

  task automatic check_i(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_v(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the next R beat of the oldest accepted burst, if any.
  task automatic drive_slave();
    logic [7:0] b8;
    b8 = 8'(beat_idx);
    if (rv_en && slv_ar_q.size() > 0) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = {7'd0, slv_ar_q[0], b8, {26{b8}}};
      m_axi.rresp  = (burst_cnt == err_burst && beat_idx == 3) ? 2'b10 : 2'b00;
      m_axi.rlast  = (beat_idx == BL - 1);
    end else begin
      m_axi.rvalid = 1'b0;
      m_axi.rdata  = '0;
      m_axi.rresp  = 2'b00;
      m_axi.rlast  = 1'b0;
    end
  endtask

  // One clock: account for handshakes at this edge, check outputs, then set up the next cycle.
  task automatic tick();
    logic ar_hs, r_hs;
    @(posedge clk);
    #1;
    ar_hs = snap_arvalid && m_axi.arready;
    r_hs  = m_axi.rvalid && snap_rready;
    if (snap_arvalid && !m_axi.arready) begin
      check_i("arvalid_hold", int'(m_axi.arvalid), 1);
      check_v("araddr_hold", DW'(m_axi.araddr), DW'(snap_araddr));
    end
    if (ar_hs) begin
      ar_cnt++;
      slv_ar_q.push_back(snap_araddr);
      check_i("ar_expected", int'(exp_addr_q.size() > 0), 1);
      if (exp_addr_q.size() > 0) check_v("araddr", DW'(snap_araddr), DW'(exp_addr_q.pop_front()));
    end
    if (r_hs) begin
      exp_data_q.push_back(m_axi.rdata);
      if (m_axi.rlast) begin
        void'(slv_ar_q.pop_front());
        beat_idx = 0;
        burst_cnt++;
      end else begin
        beat_idx++;
      end
    end
    check_i("push_latency", int'(fifo_write_enable), int'(r_hs));
    if (fifo_write_enable && exp_data_q.size() > 0) begin
      push_cnt++;
      check_v("push_data", fifo_write_data, exp_data_q.pop_front());
    end
    if (done) done_cnt++;
    drive_slave();
    snap_arvalid = m_axi.arvalid;
    snap_rready  = m_axi.rready;
    snap_araddr  = m_axi.araddr;
  endtask

  task automatic start_run(input logic [AW-1:0] base, input int n);
    base_addr  = base;
    num_bursts = 16'(n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(base + AW'(i) * STEP);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int d0, i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < bound) begin
      tick();
      i++;
    end
    check_i({tag, "_done_seen"}, int'(done_cnt > d0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_i({tag, "_busy"}, int'(busy), 0);
    check_i({tag, "_done"}, int'(done), 0);
    check_i({tag, "_arvalid"}, int'(m_axi.arvalid), 0);
    check_v({tag, "_araddr"}, DW'(m_axi.araddr), '0);
    check_i({tag, "_rready"}, int'(m_axi.rready), 0);
    check_i({tag, "_fifo_we"}, int'(fifo_write_enable), 0);
    check_v({tag, "_fifo_wd"}, fifo_write_data, '0);
    check_i({tag, "_rd_err"}, int'(rd_err), 0);
  endtask

  initial begin
    int a0, p0, d0;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_bursts = 16'd0;
    fifo_read_enable = 1'b0; m_axi.arready = 1'b1;
    drive_slave();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    tick();

    // Four bursts from 0, consumer pops every cycle.
    fifo_read_enable = 1'b1;
    a0 = ar_cnt; p0 = push_cnt; d0 = done_cnt;
    start_run(33'h0, 4);
    check_i("A_arvalid_first", int'(m_axi.arvalid), 1);
    check_i("A_busy", int'(busy), 1);
    wait_done("A", 500);
    tick();
    check_i("A_ar_count", ar_cnt - a0, 4);
    check_i("A_push_count", push_cnt - p0, 64);
    check_i("A_done_pulses", done_cnt - d0, 1);
    check_i("A_busy_after", int'(busy), 0);
    check_i("A_addr_left", exp_addr_q.size(), 0);

    // Zero-length job: no AR, done two cycles after start.
    a0 = ar_cnt;
    start_run(33'h40000, 0);
    check_i("B_busy", int'(busy), 1);
    check_i("B_done_early", int'(done), 0);
    tick();
    check_i("B_done", int'(done), 1);
    tick();
    check_i("B_done_pulse", int'(done), 0);
    check_i("B_ar_count", ar_cnt - a0, 0);

    // arready held low: request must stay stable; a start while busy is ignored.
    m_axi.arready = 1'b0;
    a0 = ar_cnt; d0 = done_cnt;
    start_run(33'h1000, 1);
    check_i("C_arvalid", int'(m_axi.arvalid), 1);
    check_v("C_araddr", DW'(m_axi.araddr), DW'(33'h1000));
    tick(); tick();
    base_addr = 33'h8000; num_bursts = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    m_axi.arready = 1'b1;
    wait_done("C", 200);
    tick();
    check_i("C_ar_count", ar_cnt - a0, 1);
    check_i("C_done_pulses", done_cnt - d0, 1);

    // SLVERR on beat 3: data still pushed, flag depends on build option.
    err_burst = burst_cnt;
    p0 = push_cnt;
    start_run(33'h2000, 1);
    wait_done("D", 200);
    check_i("D_push_count", push_cnt - p0, 16);
`ifdef HBM_RD_RESP_CHK_EN
    check_i("D_rd_err", int'(rd_err), 1);
`else
    check_i("D_rd_err", int'(rd_err), 0);
`endif
    err_burst = -1;
    start_run(33'h0, 0);
    check_i("D_rd_err_cleared", int'(rd_err), 0);
    wait_done("D2", 10);

    // Reset in DRAIN with data withheld and no pops (credits left at 480).
    fifo_read_enable = 1'b0;
    rv_en = 1'b0;
    a0 = ar_cnt;
    start_run(33'h3000, 2);
    for (int i = 0; i < 20 && ar_cnt < a0 + 2; i++) tick();
    tick();
    check_i("E_ar_count", ar_cnt - a0, 2);
    check_i("E_busy", int'(busy), 1);
    check_i("E_rready", int'(m_axi.rready), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("E_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    slv_ar_q.delete(); exp_data_q.delete(); exp_addr_q.delete();
    beat_idx = 0; rv_en = 1'b1;
    drive_slave();
    snap_arvalid = m_axi.arvalid; snap_rready = m_axi.rready; snap_araddr = m_axi.araddr;
    tick();
    check_reset_outputs("E_post");

    // 40 bursts without pops: full credit pool allows exactly 32 ARs.
    a0 = ar_cnt; p0 = push_cnt;
    start_run(33'h0, 40);
    repeat (700) tick();
    check_i("F_ar_32", ar_cnt - a0, 32);
    check_i("F_arvalid_low", int'(m_axi.arvalid), 0);
    check_i("F_push_512", push_cnt - p0, 512);
    fifo_read_enable = 1'b1;
    repeat (15) tick();
    check_i("F_ar_15pops", ar_cnt - a0, 32);
    tick();
    fifo_read_enable = 1'b0;
    repeat (10) tick();
    check_i("F_ar_33", ar_cnt - a0, 33);
    fifo_read_enable = 1'b1;
    wait_done("F", 2000);
    check_i("F_ar_total", ar_cnt - a0, 40);
    check_i("F_push_total", push_cnt - p0, 640);
    check_i("F_addr_left", exp_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
